// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared constants, FSM state type and helper functions for the
//            5-stage MIPS hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  // Operand source selects used by both the D-stage and E-stage muxes
  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_M    = 2'd1;
  localparam logic [1:0] FWD_W    = 2'd2;

  // Tuse encoding for "operand not read by this instruction"
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Default latencies of the iterative multiply/divide unit
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // M wins over W; M only when its result already exists; $0 never forwards
  function automatic logic [1:0] fwd_select(input logic [4:0] src,
                                            input logic [4:0] wa_m,
                                            input logic [1:0] tnew_m,
                                            input logic [4:0] wa_w);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (src != 5'd0) begin
      if ((src == wa_m) && (tnew_m == 2'd0)) begin
        sel = FWD_M;
      end else if (src == wa_w) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  // Producer in a later stage will not have the value by the time it is used
  function automatic logic data_hazard(input logic [4:0] src,
                                       input logic [1:0] tuse,
                                       input logic [4:0] wa,
                                       input logic [1:0] tnew);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (src == wa) && (tuse < tnew);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Datapath <-> hazard controller signal bundle.
//            master = datapath side, slave = hazard controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;
  logic [4:0] rs_e;
  logic [4:0] rt_e;
  logic [4:0] wa_e;
  logic [4:0] wa_m;
  logic [4:0] wa_w;
  logic [1:0] tnew_e;
  logic [1:0] tnew_m;
  logic       md_start_e;
  logic       md_is_div_e;
  logic       md_use_d;

  logic       en_pc;
  logic       en_fd;
  logic       clr_de;
  logic [1:0] fwd_rs_d;
  logic [1:0] fwd_rt_d;
  logic [1:0] fwd_rs_e;
  logic [1:0] fwd_rt_e;
  logic       md_busy;

  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, rs_e, rt_e,
           wa_e, wa_m, wa_w, tnew_e, tnew_m,
           md_start_e, md_is_div_e, md_use_d,
    input  en_pc, en_fd, clr_de,
           fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, rs_e, rt_e,
           wa_e, wa_m, wa_w, tnew_e, tnew_m,
           md_start_e, md_is_div_e, md_use_d,
    output en_pc, en_fd, clr_de,
           fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_md_busy_seq.sv
`default_nettype none
// ============================================================================
// Module   : md_busy_seq
// Purpose  : Busy sequencer for the iterative mult/div unit. Busy rises the
//            cycle after a start and stays high for exactly N cycles.
// Revision : 1.0 - initial release
// ============================================================================
module md_busy_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic md_start_i,
  input  wire logic md_is_div_i,
  output logic      md_busy_o
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: a start (re)loads the counter; BUSY ends on the count-1 cycle
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (md_start_i) begin
      state_d = MD_BUSY;
      count_d = md_is_div_i ? DIV_LOAD : MULT_LOAD;
    end else begin
      case (state_q)
        MD_IDLE: begin
          count_d = '0;
        end
        MD_BUSY: begin
          if (count_q == CNT_ONE) begin
            state_d = MD_IDLE;
            count_d = '0;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        default: begin
          state_d = MD_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign md_busy_o = (state_q == MD_BUSY);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Stall, bubble and forwarding control for the 5-stage MIPS core,
//            plus the mult/div busy sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input wire logic     clk,
  input wire logic     reset,
  hazard_ctrl_if.slave hz
);

  logic w_md_busy;
  logic w_data_stall;
  logic w_md_stall;
  logic w_stall;

  md_busy_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_seq (
    .clk         (clk),
    .reset       (reset),
    .md_start_i  (hz.md_start_e),
    .md_is_div_i (hz.md_is_div_e),
    .md_busy_o   (w_md_busy)
  );

  // Stall decision: either operand waits on E or M, or the mult/div unit is occupied
  always_comb begin
    w_data_stall = data_hazard(hz.rs_d, hz.tuse_rs_d, hz.wa_e, hz.tnew_e) |
                   data_hazard(hz.rs_d, hz.tuse_rs_d, hz.wa_m, hz.tnew_m) |
                   data_hazard(hz.rt_d, hz.tuse_rt_d, hz.wa_e, hz.tnew_e) |
                   data_hazard(hz.rt_d, hz.tuse_rt_d, hz.wa_m, hz.tnew_m);
    w_md_stall   = hz.md_use_d & (w_md_busy | hz.md_start_e);
    w_stall      = w_data_stall | w_md_stall;
  end

  // A single stall freezes PC and F/D and injects one bubble into D/E
  assign hz.en_pc   = ~w_stall;
  assign hz.en_fd   = ~w_stall;
  assign hz.clr_de  = w_stall;
  assign hz.md_busy = w_md_busy;

  assign hz.fwd_rs_d = fwd_select(hz.rs_d, hz.wa_m, hz.tnew_m, hz.wa_w);
  assign hz.fwd_rt_d = fwd_select(hz.rt_d, hz.wa_m, hz.tnew_m, hz.wa_w);
  assign hz.fwd_rs_e = fwd_select(hz.rs_e, hz.wa_m, hz.tnew_m, hz.wa_w);
  assign hz.fwd_rt_e = fwd_select(hz.rt_e, hz.wa_m, hz.tnew_m, hz.wa_w);

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Scoreboard bench for hazard_ctrl: directed scenarios followed by
//            random traffic, checked against a cycle-indexed reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  typedef struct {
    logic       reset;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
    logic       md_start_e, md_is_div_e, md_use_d;
  } stim_t;

  typedef struct {
    int         cyc;
    logic       en_pc, en_fd, clr_de, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();

  hazard_ctrl #(
    .MULT_CYCLES (N_MULT),
    .DIV_CYCLES  (N_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  // The unit is busy during cycles md_begin..md_end inclusive
  int   md_begin = 1;
  int   md_end   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  function automatic logic [1:0] ref_fwd(input logic [4:0] r, input logic [4:0] wam,
                                         input logic [1:0] tnm, input logic [4:0] waw);
    if (r == 5'd0) return 2'd0;
    if (r == wam && tnm == 2'd0) return 2'd1;
    if (r == waw) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit must_wait(input logic [4:0] r, input logic [1:0] tuse,
                                   input logic [4:0] wa, input logic [1:0] tnew);
    return (r != 5'd0) && (r == wa) && (tuse < tnew);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.reset = 1'b0;
    s.rs_d = 0; s.rt_d = 0; s.rs_e = 0; s.rt_e = 0;
    s.wa_e = 0; s.wa_m = 0; s.wa_w = 0;
    s.tuse_rs_d = 2'd3; s.tuse_rt_d = 2'd3; s.tnew_e = 0; s.tnew_m = 0;
    s.md_start_e = 0; s.md_is_div_e = 0; s.md_use_d = 0;
    return s;
  endfunction

  task automatic check(input string name, input int c, input logic [1:0] act, input logic [1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, c, act, expv);
    end
  endtask

  // Drive one cycle of stimulus and queue the model's prediction for it
  task automatic apply(input stim_t s);
    exp_t e;
    bit   busy, stall;
    @(posedge clk);
    #1;
    reset          = s.reset;
    hz.rs_d        = s.rs_d;      hz.rt_d      = s.rt_d;
    hz.tuse_rs_d   = s.tuse_rs_d; hz.tuse_rt_d = s.tuse_rt_d;
    hz.rs_e        = s.rs_e;      hz.rt_e      = s.rt_e;
    hz.wa_e        = s.wa_e;      hz.wa_m      = s.wa_m;   hz.wa_w = s.wa_w;
    hz.tnew_e      = s.tnew_e;    hz.tnew_m    = s.tnew_m;
    hz.md_start_e  = s.md_start_e;
    hz.md_is_div_e = s.md_is_div_e;
    hz.md_use_d    = s.md_use_d;

    busy  = (cyc >= md_begin) && (cyc <= md_end);
    stall = must_wait(s.rs_d, s.tuse_rs_d, s.wa_e, s.tnew_e) ||
            must_wait(s.rs_d, s.tuse_rs_d, s.wa_m, s.tnew_m) ||
            must_wait(s.rt_d, s.tuse_rt_d, s.wa_e, s.tnew_e) ||
            must_wait(s.rt_d, s.tuse_rt_d, s.wa_m, s.tnew_m) ||
            (s.md_use_d && (busy || s.md_start_e));
    e.cyc      = cyc;
    e.en_pc    = !stall;
    e.en_fd    = !stall;
    e.clr_de   = stall;
    e.md_busy  = busy;
    e.fwd_rs_d = ref_fwd(s.rs_d, s.wa_m, s.tnew_m, s.wa_w);
    e.fwd_rt_d = ref_fwd(s.rt_d, s.wa_m, s.tnew_m, s.wa_w);
    e.fwd_rs_e = ref_fwd(s.rs_e, s.wa_m, s.tnew_m, s.wa_w);
    e.fwd_rt_e = ref_fwd(s.rt_e, s.wa_m, s.tnew_m, s.wa_w);
    exp_q.push_back(e);

    if (s.reset) begin
      md_end = cyc;
    end else if (s.md_start_e) begin
      md_begin = cyc + 1;
      md_end   = cyc + (s.md_is_div_e ? N_DIV : N_MULT);
    end
    cyc++;
  endtask

  // Monitor: compare every predicted cycle against the DUT mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("en_pc",    mon_e.cyc, {1'b0, hz.en_pc},   {1'b0, mon_e.en_pc});
      check("en_fd",    mon_e.cyc, {1'b0, hz.en_fd},   {1'b0, mon_e.en_fd});
      check("clr_de",   mon_e.cyc, {1'b0, hz.clr_de},  {1'b0, mon_e.clr_de});
      check("md_busy",  mon_e.cyc, {1'b0, hz.md_busy}, {1'b0, mon_e.md_busy});
      check("fwd_rs_d", mon_e.cyc, hz.fwd_rs_d, mon_e.fwd_rs_d);
      check("fwd_rt_d", mon_e.cyc, hz.fwd_rt_d, mon_e.fwd_rt_d);
      check("fwd_rs_e", mon_e.cyc, hz.fwd_rs_e, mon_e.fwd_rs_e);
      check("fwd_rt_e", mon_e.cyc, hz.fwd_rt_e, mon_e.fwd_rt_e);
    end
  end

  initial begin
    stim_t s;
    s = idle();
    reset          = 1'b1;
    hz.rs_d        = 0; hz.rt_d = 0; hz.rs_e = 0; hz.rt_e = 0;
    hz.wa_e        = 0; hz.wa_m = 0; hz.wa_w = 0;
    hz.tuse_rs_d   = 2'd3; hz.tuse_rt_d = 2'd3; hz.tnew_e = 0; hz.tnew_m = 0;
    hz.md_start_e  = 0; hz.md_is_div_e = 0; hz.md_use_d = 0;

    // Reset state with all-zero inputs
    s = idle(); s.reset = 1'b1; s.tuse_rs_d = 0; s.tuse_rt_d = 0;
    apply(s); apply(s);

    // lw $1 moving E -> M -> W, consumer in D needs rs in E
    s = idle(); s.rs_d = 1; s.tuse_rs_d = 1; s.wa_e = 1; s.tnew_e = 2;
    apply(s);
    s = idle(); s.rs_d = 1; s.tuse_rs_d = 1; s.wa_m = 1; s.tnew_m = 1;
    apply(s);
    s = idle(); s.rs_d = 1; s.tuse_rs_d = 1; s.wa_w = 1;
    apply(s);

    // addu $3 forwarding to E: M only, W only, both
    s = idle(); s.rt_e = 3; s.wa_m = 3; apply(s);
    s = idle(); s.rt_e = 3; s.wa_w = 3; apply(s);
    s = idle(); s.rt_e = 3; s.wa_m = 3; s.wa_w = 3; apply(s);

    // Writes to $0 everywhere never stall or forward
    s = idle(); s.tuse_rs_d = 0; s.tuse_rt_d = 0; s.tnew_e = 2; s.tnew_m = 1;
    apply(s);

    // mult in E with mflo in D: 6 stalled cycles then release
    s = idle(); s.md_start_e = 1; s.md_use_d = 1; apply(s);
    s = idle(); s.md_use_d = 1;
    for (int i = 0; i < N_MULT + 2; i++) apply(s);

    // div then reset in its 3rd busy cycle
    s = idle(); s.md_start_e = 1; s.md_is_div_e = 1; apply(s);
    s = idle(); s.md_use_d = 1; apply(s); apply(s);
    s.reset = 1'b1; apply(s);
    s.reset = 1'b0; apply(s); apply(s);

    // Data stall overlapping an MD stall
    s = idle(); s.md_start_e = 1; s.md_use_d = 1; s.rs_d = 4; s.tuse_rs_d = 0;
    s.wa_e = 4; s.tnew_e = 1; apply(s);
    s = idle(); s.md_use_d = 1; s.rs_d = 4; s.tuse_rs_d = 0; s.wa_m = 4; s.tnew_m = 1;
    apply(s);
    s = idle(); s.md_use_d = 1;
    for (int i = 0; i < N_MULT + 1; i++) apply(s);

    // Random traffic over a small register window to force collisions
    for (int i = 0; i < 600; i++) begin
      s.reset       = ($urandom_range(0, 59) == 0);
      s.rs_d        = 5'($urandom_range(0, 3));
      s.rt_d        = 5'($urandom_range(0, 3));
      s.rs_e        = 5'($urandom_range(0, 3));
      s.rt_e        = 5'($urandom_range(0, 3));
      s.wa_e        = 5'($urandom_range(0, 3));
      s.wa_m        = 5'($urandom_range(0, 3));
      s.wa_w        = 5'($urandom_range(0, 3));
      s.tuse_rs_d   = 2'($urandom_range(0, 3));
      s.tuse_rt_d   = 2'($urandom_range(0, 3));
      s.tnew_e      = 2'($urandom_range(0, 3));
      s.tnew_m      = 2'($urandom_range(0, 3));
      s.md_start_e  = ($urandom_range(0, 9) == 0);
      s.md_is_div_e = 1'($urandom_range(0, 1));
      s.md_use_d    = ($urandom_range(0, 2) == 0);
      apply(s);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
